// File: rtl/cmos_stream_gen.sv
// cmos_stream_gen: synthetic CMOS-sensor pixel stream (vsync/href/valid/RGB565)
// with runtime frame geometry and a selectable position-dependent test pattern.
//
// state  | meaning
// IDLE   | waiting for enable and non-zero geometry
// VSYNC  | frame sync pulse, V_SYNC_LEN cycles
// VBACK  | vertical back porch, V_BACK_LEN cycles
// LINE   | active line, t_width*PIX_DIV cycles
// HBLANK | horizontal blanking after every line, H_BLANK cycles
//
// Outputs are registered from next-state values, so vsync of a new frame rises
// on the same edge that frame_done of the previous one does. enable is
// registered once, which gives one edge of start latency from IDLE.
module cmos_stream_gen #(
  parameter int V_SYNC_LEN = 16,
  parameter int V_BACK_LEN = 32,
  parameter int H_BLANK    = 64,
  parameter int PIX_DIV    = 1
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [9:0]  t_width,
  input  logic [9:0]  t_high,
  input  logic [1:0]  pattern_sel,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_frame_data,
  output logic        frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK} state_t;
  localparam int CW = 16;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          en_q;
  logic          vsync_q, href_q, valid_q, done_q;
  logic [15:0]   data_q;

  logic          start_ok, last_cnt, last_line, load, emit, done_d;
  logic [9:0]    px;
  logic [15:0]   pix_d;
  logic [CW-1:0] line_len_m1;

  assign start_ok    = en_q && (t_width != 10'd0) && (t_high != 10'd0);
  assign last_cnt    = (cnt_q == '0);
  assign last_line   = (y_q == h_q - 10'd1);
  assign line_len_m1 = CW'(w_q) * CW'(PIX_DIV) - CW'(1);

  // Next-state, phase down-counter, line counter and config latch on frame start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: load = start_ok;
      S_VSYNC:
        if (last_cnt) begin
          state_d = S_VBACK;
          cnt_d   = CW'(V_BACK_LEN - 1);
        end else cnt_d = cnt_q - CW'(1);
      S_VBACK:
        if (last_cnt) begin
          state_d = S_LINE;
          cnt_d   = line_len_m1;
        end else cnt_d = cnt_q - CW'(1);
      S_LINE:
        if (last_cnt) begin
          state_d = S_HBLANK;
          cnt_d   = CW'(H_BLANK - 1);
        end else cnt_d = cnt_q - CW'(1);
      S_HBLANK:
        if (last_cnt) begin
          if (last_line) begin
            done_d  = 1'b1;
            load    = start_ok;
            state_d = S_IDLE;
          end else begin
            state_d = S_LINE;
            cnt_d   = line_len_m1;
            y_d     = y_q + 10'd1;
          end
        end else cnt_d = cnt_q - CW'(1);
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_VSYNC;
      cnt_d   = CW'(V_SYNC_LEN - 1);
      w_d     = t_width;
      h_d     = t_high;
      sel_d   = pattern_sel;
      y_d     = 10'd0;
    end
  end

  // Pixel strobe, current x coordinate and pattern generation
  always_comb begin
    emit   = (state_d == S_LINE) && ((PIX_DIV == 1) || cnt_d[0]);
    px     = (state_q == S_LINE) ? x_q : 10'd0;
    x_d    = emit ? px + 10'd1 : x_q;
    fcnt_d = fcnt_q + {7'd0, done_d};
    unique case (sel_q)
      2'd0: pix_d = {y_d[5:0], px};
      2'd1:
        unique case (px[8:6])
          3'd0:    pix_d = 16'hFFFF;
          3'd1:    pix_d = 16'hFFE0;
          3'd2:    pix_d = 16'h07FF;
          3'd3:    pix_d = 16'h07E0;
          3'd4:    pix_d = 16'hF81F;
          3'd5:    pix_d = 16'hF800;
          3'd6:    pix_d = 16'h001F;
          default: pix_d = 16'h0000;
        endcase
      2'd2:    pix_d = (px[3] ^ y_d[3]) ? 16'hFFFF : 16'h0000;
      default: pix_d = {fcnt_q, fcnt_q};
    endcase
  end

  // State, counters, latched config and registered stream outputs
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      sel_q   <= '0;
      fcnt_q  <= '0;
      en_q    <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      sel_q   <= sel_d;
      fcnt_q  <= fcnt_d;
      en_q    <= enable;
      vsync_q <= (state_d == S_VSYNC);
      href_q  <= (state_d == S_LINE);
      valid_q <= emit;
      done_q  <= done_d;
      if (emit) data_q <= pix_d;
    end
  end

  assign cmos_frame_vsync = vsync_q;
  assign cmos_frame_href  = href_q;
  assign cmos_frame_valid = valid_q;
  assign cmos_frame_data  = data_q;
  assign frame_done       = done_q;

endmodule

// File: tb/tb_cmos_stream_gen.sv
// Directed bench for cmos_stream_gen: default-geometry instance (a) and a
// PIX_DIV=2 instance with short blanking (b).
module tb_cmos_stream_gen;

  localparam int MAXC = 1100;
  localparam int VS = 0, HR = 1, VA = 2, FD = 3;

  logic        cam_pclk = 1'b0;
  logic        rst_n;
  logic        enable, enable_b;
  logic [9:0]  t_width, t_high, t_width_b, t_high_b;
  logic [1:0]  pattern_sel, pattern_sel_b;
  logic        a_vs, a_hr, a_va, a_fd, b_vs, b_hr, b_va, b_fd;
  logic [15:0] a_dt, b_dt;

  always #5 cam_pclk = ~cam_pclk;

  cmos_stream_gen u_a (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .enable(enable),
    .t_width(t_width), .t_high(t_high), .pattern_sel(pattern_sel),
    .cmos_frame_vsync(a_vs), .cmos_frame_href(a_hr), .cmos_frame_valid(a_va),
    .cmos_frame_data(a_dt), .frame_done(a_fd)
  );

  cmos_stream_gen #(.V_SYNC_LEN(2), .V_BACK_LEN(2), .H_BLANK(4), .PIX_DIV(2)) u_b (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .enable(enable_b),
    .t_width(t_width_b), .t_high(t_high_b), .pattern_sel(pattern_sel_b),
    .cmos_frame_vsync(b_vs), .cmos_frame_href(b_hr), .cmos_frame_valid(b_va),
    .cmos_frame_data(b_dt), .frame_done(b_fd)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  sa [MAXC];
  logic [3:0]  sb [MAXC];
  logic [15:0] db [MAXC];
  int          ncap;
  logic [15:0] pa [$];
  logic [15:0] pb [$];
  int          fdata [257];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // record n cycles of both instances; at index drop_at, drop enable and widen a
  task automatic capture(input int n, input int drop_at);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge cam_pclk);
      sa[i] = {a_fd, a_va, a_hr, a_vs};
      sb[i] = {b_fd, b_va, b_hr, b_vs};
      db[i] = b_dt;
      if (a_va) pa.push_back(a_dt);
      if (b_va) pb.push_back(b_dt);
      if (i == drop_at) begin
        enable  = 1'b0;
        t_width = 10'd8;
      end
    end
    ncap = n;
  endtask

  task automatic do_reset();
    enable   = 1'b0;
    enable_b = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge cam_pclk);
    rst_n = 1'b1;
  endtask

  function automatic bit sig(input int d, input int b, input int i);
    return (d == 0) ? sa[i][b] : sb[i][b];
  endfunction

  function automatic int first_rise(input int d, input int b, input int from);
    for (int i = from; i < ncap; i++)
      if (sig(d, b, i) && (i == 0 || !sig(d, b, i - 1))) return i;
    return -1;
  endfunction

  function automatic int count_rises(input int d, input int b);
    int c = 0;
    for (int i = 0; i < ncap; i++)
      if (sig(d, b, i) && (i == 0 || !sig(d, b, i - 1))) c++;
    return c;
  endfunction

  function automatic int run_len(input int d, input int b, input int start);
    int c = 0;
    if (start < 0) return -1;
    for (int i = start; i < ncap && sig(d, b, i); i++) c++;
    return c;
  endfunction

  function automatic int count_bad(input int d);
    int c = 0;
    for (int i = 0; i < ncap; i++)
      if ((sig(d, VS, i) && sig(d, HR, i)) || (sig(d, VA, i) && !sig(d, HR, i))) c++;
    return c;
  endfunction

  function automatic int pxa(input int k);
    return (k < pa.size()) ? int'(pa[k]) : -1;
  endfunction

  function automatic int pxb(input int k);
    return (k < pb.size()) ? int'(pb[k]) : -1;
  endfunction

  initial begin
    int vs_r, hr_r, hr2, ok, pix, nf;
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    rst_n = 1'b0; enable = 1'b0; enable_b = 1'b0;
    t_width = 10'd4; t_high = 10'd2; pattern_sel = 2'd0;
    t_width_b = 10'd3; t_high_b = 10'd1; pattern_sel_b = 2'd0;
    repeat (3) @(negedge cam_pclk);
    check("reset_outputs_a", {a_vs, a_hr, a_va, a_fd, a_dt}, 0);
    check("reset_outputs_b", {b_vs, b_hr, b_va, b_fd, b_dt}, 0);
    rst_n = 1'b1;

    // coordinate pattern, default geometry, continuous
    enable = 1'b1;
    capture(400, -1);
    vs_r = first_rise(0, VS, 0);
    check("start_latency", vs_r, 1);
    check("vsync_len", run_len(0, VS, vs_r), 16);
    hr_r = first_rise(0, HR, 0);
    check("vback_gap", hr_r - (vs_r + run_len(0, VS, vs_r)), 32);
    check("href_len", run_len(0, HR, hr_r), 4);
    hr2 = first_rise(0, HR, hr_r + 1);
    check("hblank_gap", hr2 - (hr_r + 4), 64);
    for (int k = 0; k < 8; k++)
      check($sformatf("coord_px%0d", k), pxa(k), (k < 4) ? k : 16'h0400 + k - 4);
    check("frame_done_idx", first_rise(0, FD, 0), 185);
    check("frame_done_len", run_len(0, FD, first_rise(0, FD, 0)), 1);
    check("frame_period", first_rise(0, VS, vs_r + 1) - vs_r, 184);
    check("no_overlap_a", count_bad(0), 0);

    // asynchronous reset in the middle of a line, then restart
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge cam_pclk);
      if (a_hr) ok = 1;
    end
    check("wait_href", ok, 1);
    @(negedge cam_pclk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {a_vs, a_hr, a_va, a_fd, a_dt}, 0);
    @(negedge cam_pclk);
    rst_n = 1'b1;
    capture(200, -1);
    check("restart_latency", first_rise(0, VS, 0), 1);
    check("restart_px0", pxa(0), 16'h0000);
    check("restart_px4", pxa(4), 16'h0400);
    check("restart_npix", pa.size(), 8);

    // drop enable and change width during line 0
    do_reset();
    t_width = 10'd4; t_high = 10'd2; enable = 1'b1;
    capture(400, 50);
    check("drop_npix", pa.size(), 8);
    check("drop_last_px", pxa(7), 16'h0403);
    check("drop_vsyncs", count_rises(0, VS), 1);
    check("drop_done_idx", first_rise(0, FD, 0), 185);
    check("drop_dones", count_rises(0, FD), 1);

    // zero geometry holds IDLE
    t_width = 10'd4; t_high = 10'd0; enable = 1'b1;
    capture(1000, -1);
    check("zero_vsyncs", count_rises(0, VS), 0);
    check("zero_npix", pa.size(), 0);
    t_high = 10'd1;
    capture(200, -1);
    check("zero_then_start", first_rise(0, VS, 0), 0);

    // half-rate pixels on the PIX_DIV=2 instance
    do_reset();
    enable_b = 1'b1;
    capture(40, -1);
    check("b_vsync_len", run_len(1, VS, first_rise(1, VS, 0)), 2);
    hr_r = first_rise(1, HR, 0);
    check("b_href_rise", hr_r, 5);
    check("b_href_len", run_len(1, HR, hr_r), 6);
    check("b_valid_pat", {sb[5][VA], sb[6][VA], sb[7][VA], sb[8][VA], sb[9][VA], sb[10][VA]}, 6'b101010);
    check("b_px0", pxb(0), 0);
    check("b_px1", pxb(1), 1);
    check("b_px2", pxb(2), 2);
    check("b_data_hold", db[8], 16'h0001);
    check("b_done_idx", first_rise(1, FD, 0), 15);
    check("no_overlap_b", count_bad(1), 0);

    // colour bars across a 512-pixel line
    do_reset();
    t_width = 10'd512; t_high = 10'd1; pattern_sel = 2'd1; enable = 1'b1;
    capture(700, -1);
    for (int k = 0; k < 8; k++)
      check($sformatf("bar%0d", k), pxa(k * 64), bars[k]);
    check("bar2_end", pxa(191), 16'h07FF);
    check("bar7_end", pxa(511), 16'h0000);

    // checkerboard over 9 lines
    do_reset();
    t_width = 10'd16; t_high = 10'd9; pattern_sel = 2'd2; enable = 1'b1;
    capture(800, -1);
    check("chk_npix", pa.size(), 144);
    check("chk_y0x0", pxa(0), 16'h0000);
    check("chk_y0x8", pxa(8), 16'hFFFF);
    check("chk_y8x0", pxa(128), 16'hFFFF);
    check("chk_y8x8", pxa(136), 16'h0000);

    // frame counter pattern over 257 frames
    do_reset();
    t_width = 10'd2; t_high = 10'd1; pattern_sel = 2'd3; enable = 1'b1;
    pix = 0; nf = 0;
    for (int c = 0; c < 31000 && nf < 257; c++) begin
      @(negedge cam_pclk);
      if (a_va) begin
        if (pix % 2 == 0) begin
          fdata[nf] = int'(a_dt);
          nf++;
        end
        pix++;
      end
    end
    check("fc_frames", nf, 257);
    check("fc_frame1", fdata[0], 16'h0000);
    check("fc_frame2", fdata[1], 16'h0101);
    check("fc_frame256", fdata[255], 16'hFFFF);
    check("fc_frame257", fdata[256], 16'h0000);
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_stream_gen.md
# cmos_stream_gen

Synthetic camera-stream transmitter for the video pipeline. It produces the same vsync/href/valid/16-bit-data pixel stream that a CMOS sensor capture front end delivers, so rotation, scaling and buffering blocks can be driven and checked on-chip without a sensor. Frame geometry is set at runtime. Each generated frame carries a selectable, position-dependent test pattern.

## Interface
Parameters:
- V_SYNC_LEN, 16: cycles vsync is held high at the start of each frame (≥2).
- V_BACK_LEN, 32: cycles from the vsync falling edge to the first href rise (≥2).
- H_BLANK, 64: cycles href is low after each line (≥4).
- PIX_DIV, 1: cycles per pixel inside a line; legal values are 1 or 2.

Ports:
- cam_pclk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; while high, frames are generated back-to-back.
- t_width  in  10  active pixels per line.
- t_high  in  10  active lines per frame.
- pattern_sel  in  2  0 coordinate, 1 colour bars, 2 checkerboard, 3 frame counter.
- cmos_frame_vsync  out  1  frame sync, active-high pulse at frame start.
- cmos_frame_href  out  1  high for the whole active line.
- cmos_frame_valid  out  1  pixel strobe; only ever high while href is high.
- cmos_frame_data  out  16  RGB565 pixel; qualified by valid.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- FSM states and transitions:
  - IDLE → VSYNC when enable=1, t_width≠0 and t_high≠0.
  - VSYNC (V_SYNC_LEN cycles) → VBACK (V_BACK_LEN cycles) → LINE (t_width·PIX_DIV cycles) → HBLANK (H_BLANK cycles).
  - From HBLANK: go to LINE if more lines remain. After the last line, go to VSYNC if enable=1, otherwise IDLE.
- Configuration is latched when entering VSYNC. t_width, t_high and pattern_sel are all latched. Changes mid-frame have no effect until the next frame.
- Counters:
  - x: 10-bit, 0..t_width−1. Advances per emitted pixel and clears at the start of each line.
  - y: 10-bit, 0..t_high−1. Increments after each HBLANK.
  - frame_cnt: 8-bit. Increments at each frame_done and wraps from 255 to 0.
- Zero geometry: if t_width=0 or t_high=0, stay in IDLE and emit nothing.
- Dropping enable mid-frame lets the current frame finish completely, including the final HBLANK and frame_done. The FSM then goes to IDLE.
- PIX_DIV=1: valid=href, one pixel per cycle.
- PIX_DIV=2: valid is high on the 1st, 3rd, 5th… cycle of LINE. x and the data output update only on those cycles.
- Patterns (x, y are the coordinates of the pixel being emitted):
  - 0: {y[5:0], x[9:0]}.
  - 1: bar = x[8:6], mapped to white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - 2: (x[3]^y[3]) ? FFFF : 0000.
  - 3: {frame_cnt, frame_cnt}, where frame_cnt is the count of frames completed so far.
- cmos_frame_data holds its last value while valid=0.

## Timing
- Reset values: all outputs are 0. State IDLE, x=y=frame_cnt=0. Reset takes effect asynchronously at any point, including mid-frame, and no partial line continues afterwards.
- All outputs are registered and change only on a cam_pclk rising edge.
- Start latency: enable sampled high at edge N (in IDLE) → vsync rises at edge N+1.
- vsync is high for exactly V_SYNC_LEN cycles.
- First href rise comes V_BACK_LEN cycles after the vsync fall.
- href is high for exactly t_width·PIX_DIV cycles per line.
- Every line emits exactly t_width valid pixels.
- Each frame emits exactly t_high href pulses and t_width·t_high valid pixels.
- Frame period in continuous mode: V_SYNC_LEN + V_BACK_LEN + t_high·(t_width·PIX_DIV + H_BLANK) cycles.
- frame_done is high for the one cycle on which the last HBLANK cycle completes. When enable is still 1, vsync rises in that same cycle.
- vsync and href are never high at the same time.

## Test plan
- Reset behaviour: assert rst_n=0 mid-line → all outputs go to 0 immediately. Release with enable=1 → a fresh frame starts with vsync, and x and y start from 0.
- Coordinate pattern: defaults, t_width=4, t_high=2, pattern 0 → vsync high 16 cycles, href rises 32 cycles after the vsync fall. Data is 0000, 0001, 0002, 0003, then after 64 blank cycles 0400…0403. frame_done pulses once; frame period is 48+2·(4+64)=184 cycles.
- Half-rate pixels: PIX_DIV=2 instance, t_width=3 → href high 6 cycles, valid pattern 1,0,1,0,1,0, data 0000/0001/0002 on the valid cycles.
- Mid-frame changes: drop enable during line 0 and change t_width to 8 → the frame completes with the original width, then the block goes to IDLE with no further vsync.
- Zero geometry: t_high=0 with enable=1 → no vsync for 1000 cycles. Setting t_high=1 then starts a frame.
- Frame-counter pattern: pattern 3, t_width=2, t_high=1, run 257 frames → the first frame's data is 0000, frame 256's is FFFF, and frame 257's wraps to 0000.
